// File: rtl/jpeg_byte_destuffer_if.sv
// Signal bundle for jpeg_byte_destuffer: compressed byte input, destuffed byte
// output, marker sideband, and status/control.
interface jpeg_byte_destuffer_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        marker_valid;
  logic [7:0]  marker_code;
  logic        seq_err;
  logic        eoi_seen;
  logic        restart;
  logic [15:0] byte_count;

  modport master (
    output in_valid, in_data, out_ready, restart,
    input  in_ready, out_valid, out_data, marker_valid, marker_code,
           seq_err, eoi_seen, byte_count
  );

  modport slave (
    input  in_valid, in_data, out_ready, restart,
    output in_ready, out_valid, out_data, marker_valid, marker_code,
           seq_err, eoi_seen, byte_count
  );
endinterface

// File: rtl/jpeg_byte_destuffer.sv
// JPEG receive-side destuffer: drops stuffed 0x00 after 0xFF and 0xFF fill bytes,
// and diverts markers to a sideband. Scan bytes go out through a 2-entry FIFO.
module jpeg_byte_destuffer (
  input  logic                  clk,
  input  logic                  rst_n,
  jpeg_byte_destuffer_if.slave  bus
);
  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    GOT_FF = 2'd1,
    MARK   = 2'd2,
    HALT   = 2'd3
  } state_t;

  state_t      state_r;
  logic [7:0]  fifo_r [2];
  logic [1:0]  count_r;
  logic [7:0]  code_r;
  logic [2:0]  rst_expect_r;
  logic        eoi_r;
  logic [15:0] byte_count_r;

  logic        accept_s;
  logic        push_s;
  logic        pop_s;
  logic [7:0]  push_data_s;
  logic        fire_s;
  logic        is_rst_s;
  logic        is_eoi_s;

  assign bus.in_ready  = ((state_r == NORMAL) || (state_r == GOT_FF)) && (count_r < 2'd2);
  assign accept_s      = bus.in_valid && bus.in_ready;
  assign pop_s         = bus.out_ready && (count_r != 2'd0);
  // A marker is signalled only once every earlier data byte has left the FIFO.
  assign fire_s        = (state_r == MARK) && (count_r == 2'd0) && !bus.restart;
  assign is_rst_s      = (code_r[7:3] == 5'b11010);
  assign is_eoi_s      = (code_r == 8'hD9);

  assign bus.out_valid    = (count_r != 2'd0);
  assign bus.out_data     = fifo_r[0];
  assign bus.marker_valid = fire_s;
  assign bus.marker_code  = code_r;
  assign bus.seq_err      = fire_s && is_rst_s && (code_r[2:0] != rst_expect_r);
  assign bus.eoi_seen     = eoi_r || (fire_s && is_eoi_s);
  assign bus.byte_count   = byte_count_r;

  // Decide whether the accepted byte produces a scan byte, and which value.
  always_comb begin
    push_s      = 1'b0;
    push_data_s = bus.in_data;
    if (accept_s && !bus.restart) begin
      case (state_r)
        NORMAL: push_s = (bus.in_data != 8'hFF);
        GOT_FF: begin
          if (bus.in_data == 8'h00) begin
            push_s      = 1'b1;
            push_data_s = 8'hFF;
          end else begin
            push_s      = 1'b0;
          end
        end
        default: push_s = 1'b0;
      endcase
    end else begin
      push_s = 1'b0;
    end
  end

  // Two-entry in-order FIFO; entry 0 is always the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_r[0] <= 8'h00;
      fifo_r[1] <= 8'h00;
      count_r   <= 2'd0;
    end else if (bus.restart) begin
      count_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) fifo_r[0] <= push_data_s;
          else                 fifo_r[1] <= push_data_s;
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          fifo_r[0] <= fifo_r[1];
          count_r   <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            fifo_r[0] <= push_data_s;
          end else begin
            fifo_r[0] <= fifo_r[1];
            fifo_r[1] <= push_data_s;
          end
        end
        default: count_r <= count_r;
      endcase
    end
  end

  // Stream parser: stuffing, fill bytes, marker capture and resolution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= NORMAL;
      code_r       <= 8'h00;
      rst_expect_r <= 3'd0;
      eoi_r        <= 1'b0;
    end else if (bus.restart) begin
      state_r      <= NORMAL;
      rst_expect_r <= 3'd0;
      eoi_r        <= 1'b0;
    end else begin
      case (state_r)
        NORMAL: begin
          if (accept_s && (bus.in_data == 8'hFF)) state_r <= GOT_FF;
        end
        GOT_FF: begin
          if (accept_s) begin
            if (bus.in_data == 8'h00) begin
              state_r <= NORMAL;
            end else if (bus.in_data != 8'hFF) begin
              code_r  <= bus.in_data;
              state_r <= MARK;
            end
          end
        end
        MARK: begin
          if (fire_s) begin
            if (is_rst_s) begin
              rst_expect_r <= code_r[2:0] + 3'd1;
              state_r      <= NORMAL;
            end else if (is_eoi_s) begin
              eoi_r   <= 1'b1;
              state_r <= HALT;
            end else begin
              state_r <= NORMAL;
            end
          end
        end
        HALT:    state_r <= HALT;
        default: state_r <= NORMAL;
      endcase
    end
  end

  // Scan byte counter, cleared by restart and by each RSTn marker; saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_count_r <= 16'h0000;
    end else if (bus.restart) begin
      byte_count_r <= 16'h0000;
    end else if (fire_s && is_rst_s) begin
      byte_count_r <= 16'h0000;
    end else if (push_s && (byte_count_r != 16'hFFFF)) begin
      byte_count_r <= byte_count_r + 16'h0001;
    end
  end
endmodule
